alu_sequencer: RTL and testbench

Microprogram sequencer that drives the combinational 32-bit ALU from the initiator side. It fetches 16-bit instructions from a synchronous ROM and presents operands and `alu_sel` to the ALU. It writes `alu_out`/`alu_carry` back into an internal 16×32 register file. A host preloads and reads back registers, starts a program at a given address, and waits for `done`.

---
 rtl/alu_seq_if.sv | 36 +++
 rtl/alu_sequencer.sv | 109 ++++++++++
 tb/tb_alu_sequencer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Bundle of start/status, ROM, ALU and host register-file signals around alu_sequencer.
// slave = the sequencer, master = the environment (host, ROM and ALU).
interface alu_seq_if #(parameter int ADDR_W = 8);
   logic              start;
   logic [ADDR_W-1:0] start_addr;
   logic              busy;
   logic              done;
   logic              illegal;
   logic [ADDR_W-1:0] rom_addr;
   logic [15:0]       rom_data;
   logic [31:0]       alu_a;
   logic [31:0]       alu_b;
   logic [3:0]        alu_sel;
   logic [31:0]       alu_out;
   logic              alu_carry;
   logic              carry_flag;
   logic              host_we;
   logic [3:0]        host_addr;
   logic [31:0]       host_wdata;
   logic [3:0]        host_raddr;
   logic [31:0]       host_rdata;

   modport slave (
      input  start, start_addr, rom_data, alu_out, alu_carry,
             host_we, host_addr, host_wdata, host_raddr,
      output busy, done, illegal, rom_addr, alu_a, alu_b, alu_sel,
             carry_flag, host_rdata
   );

   modport master (
      output start, start_addr, rom_data, alu_out, alu_carry,
             host_we, host_addr, host_wdata, host_raddr,
      input  busy, done, illegal, rom_addr, alu_a, alu_b, alu_sel,
             carry_flag, host_rdata
   );
endinterface

// File: rtl/alu_sequencer.sv
// Microprogram sequencer: fetches 16-bit instructions from a synchronous ROM,
// drives an external combinational ALU and writes results into a 16x32 register file.
module alu_sequencer #(
   parameter int ADDR_W = 8
) (
   input logic       clk,
   input logic       rst_n,
   alu_seq_if.slave  bus
);
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_FETCH  = 2'd1;
   localparam logic [1:0] S_DECODE = 2'd2;
   localparam logic [1:0] S_EXEC   = 2'd3;
   localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   typedef struct packed {
      logic [3:0] op;
      logic [3:0] rd;
      logic [3:0] rs1;
      logic [3:0] rs2;
   } insn_t;

   logic [1:0]        state;
   logic [ADDR_W-1:0] pc;
   insn_t             ir;
   insn_t             rom_insn;
   logic              done_q;
   logic              illegal_q;
   logic              carry_q;
   logic [31:0]       alu_a_q;
   logic [31:0]       alu_b_q;
   logic [3:0]        alu_sel_q;
   logic [15:0][31:0] rf;
   logic              dec_legal;
   logic              ir_legal;

   function automatic logic is_legal(input logic [3:0] op);
      case (op)
         4'd1, 4'd3, 4'd4, 4'd8, 4'd10, 4'd13, 4'd15: return 1'b1;
         default:                                     return 1'b0;
      endcase
   endfunction

   assign rom_insn  = insn_t'(bus.rom_data);
   assign dec_legal = is_legal(rom_insn.op);
   assign ir_legal  = is_legal(ir.op);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         pc        <= '0;
         ir        <= '0;
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
         carry_q   <= 1'b0;
         alu_a_q   <= '0;
         alu_b_q   <= '0;
         alu_sel_q <= 4'd1;
         rf        <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               // Host write lands on the same edge as start, so the program sees it.
               if (bus.host_we) rf[bus.host_addr] <= bus.host_wdata;
               if (bus.start) begin
                  pc        <= bus.start_addr;
                  illegal_q <= 1'b0;
                  state     <= S_FETCH;
               end
            end
            S_FETCH: state <= S_DECODE;
            S_DECODE: begin
               ir <= rom_insn;
               if (rom_insn.op == 4'd0) begin
                  done_q <= 1'b1;
                  state  <= S_IDLE;
               end else begin
                  alu_a_q <= rf[rom_insn.rs1];
                  alu_b_q <= rf[rom_insn.rs2];
                  // Unsupported ops keep the previous select so the ALU sees no new function.
                  if (dec_legal) alu_sel_q <= rom_insn.op;
                  else           illegal_q <= 1'b1;
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (ir_legal) begin
                  rf[ir.rd] <= bus.alu_out;
                  carry_q   <= bus.alu_carry;
               end
               pc    <= pc + PC_ONE;
               state <= S_FETCH;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy       = (state != S_IDLE);
   assign bus.done       = done_q;
   assign bus.illegal    = illegal_q;
   assign bus.rom_addr   = pc;
   assign bus.alu_a      = alu_a_q;
   assign bus.alu_b      = alu_b_q;
   assign bus.alu_sel    = alu_sel_q;
   assign bus.carry_flag = carry_q;
   assign bus.host_rdata = rf[bus.host_raddr];
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ROM and ALU.
module tb_alu_sequencer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic [15:0] rom [256];

   always #5 clk = ~clk;

   alu_seq_if #(.ADDR_W(8)) bus();
   alu_sequencer #(.ADDR_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

   always_comb begin
      bus.alu_out   = '0;
      bus.alu_carry = 1'b0;
      case (bus.alu_sel)
         4'd1:  {bus.alu_carry, bus.alu_out} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
         4'd3:  {bus.alu_carry, bus.alu_out} = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
         4'd4:  bus.alu_out = bus.alu_a & bus.alu_b;
         4'd8:  bus.alu_out = bus.alu_a | bus.alu_b;
         4'd10: bus.alu_out = (bus.alu_a > bus.alu_b) ? bus.alu_a : bus.alu_b;
         4'd13: bus.alu_out = ~bus.alu_a;
         4'd15: bus.alu_out = ~(bus.alu_a | bus.alu_b);
         default: bus.alu_out = '0;
      endcase
   end

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
   endtask

   task automatic host_write(input logic [3:0] a, input logic [31:0] d);
      bus.host_we = 1'b1; bus.host_addr = a; bus.host_wdata = d;
      @(posedge clk); #1;
      bus.host_we = 1'b0;
   endtask

   task automatic rd(input logic [3:0] a, output logic [31:0] v);
      bus.host_raddr = a;
      #1 v = bus.host_rdata;
   endtask

   // Returns in the cycle after the accepting edge, #1 past that edge.
   task automatic do_start(input logic [7:0] a);
      bus.start = 1'b1; bus.start_addr = a;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int c0, output int cyc, output bit to);
      cyc = c0; to = 1'b0;
      while (bus.done !== 1'b1) begin
         if (cyc >= 100) begin to = 1'b1; break; end
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic test_reset();
      logic [31:0] v;
      bus.start = 0; bus.start_addr = 0; bus.host_we = 0; bus.host_addr = 0;
      bus.host_wdata = 0; bus.host_raddr = 0;
      clear_rom();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
      checks++; if (bus.illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b want 0", bus.illegal); end
      checks++; if (bus.carry_flag !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b want 0", bus.carry_flag); end
      checks++; if (bus.alu_sel !== 4'd1) begin errors++; $display("FAIL reset_alu_sel: got %0d want 1", bus.alu_sel); end
      checks++; if (bus.alu_a !== 32'd0 || bus.alu_b !== 32'd0) begin errors++; $display("FAIL reset_operands: got %h/%h want 0/0", bus.alu_a, bus.alu_b); end
      checks++; if (bus.rom_addr !== 8'd0) begin errors++; $display("FAIL reset_pc: got %h want 00", bus.rom_addr); end
      rd(4'd5, v);
      checks++; if (v !== 32'd0) begin errors++; $display("FAIL reset_rf: got %h want 0", v); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_add();
      logic [31:0] v; int cyc; bit to;
      host_write(4'd1, 32'd5);
      host_write(4'd2, 32'd7);
      clear_rom(); rom[0] = 16'h1312; rom[1] = 16'h0000;
      do_start(8'h00);
      checks++; if (bus.busy !== 1'b1 || bus.rom_addr !== 8'h00) begin errors++; $display("FAIL add_first_fetch: busy=%b addr=%h want 1/00", bus.busy, bus.rom_addr); end
      wait_done(1, cyc, to);
      checks++; if (to || cyc != 6) begin errors++; $display("FAIL add_latency: got %0d timeout=%0b want 6", cyc, to); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL add_busy_at_done: got %b want 0", bus.busy); end
      rd(4'd3, v);
      checks++; if (v !== 32'd12) begin errors++; $display("FAIL add_r3: got %h want 0000000c", v); end
      checks++; if (bus.carry_flag !== 1'b0) begin errors++; $display("FAIL add_carry: got %b want 0", bus.carry_flag); end
      @(posedge clk); #1;
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL add_done_pulse: got %b want 0", bus.done); end
   endtask

   task automatic test_carry();
      logic [31:0] v; int cyc; bit to;
      host_write(4'd1, 32'hFFFF_FFFF);
      host_write(4'd2, 32'd1);
      clear_rom(); rom[4] = 16'h1412; rom[5] = 16'h0000;
      do_start(8'h04);
      wait_done(1, cyc, to);
      checks++; if (to || cyc != 6) begin errors++; $display("FAIL carry_latency: got %0d timeout=%0b want 6", cyc, to); end
      rd(4'd4, v);
      checks++; if (v !== 32'd0) begin errors++; $display("FAIL carry_r4: got %h want 0", v); end
      checks++; if (bus.carry_flag !== 1'b1) begin errors++; $display("FAIL carry_flag: got %b want 1", bus.carry_flag); end
      checks++; if (bus.illegal !== 1'b0) begin errors++; $display("FAIL carry_illegal: got %b want 0", bus.illegal); end
   endtask

   task automatic test_chain();
      logic [31:0] v; int cyc; bit to;
      host_write(4'd1, 32'h0000_F0F0);
      host_write(4'd2, 32'h0000_FF00);
      clear_rom();
      rom[0] = 16'h4512; rom[1] = 16'hD650; rom[2] = 16'hF756; rom[3] = 16'h0000;
      do_start(8'h00);
      wait_done(1, cyc, to);
      checks++; if (to || cyc != 12) begin errors++; $display("FAIL chain_latency: got %0d timeout=%0b want 12", cyc, to); end
      rd(4'd5, v);
      checks++; if (v !== 32'h0000_F000) begin errors++; $display("FAIL chain_r5: got %h want 0000f000", v); end
      rd(4'd6, v);
      checks++; if (v !== 32'hFFFF_0FFF) begin errors++; $display("FAIL chain_r6: got %h want ffff0fff", v); end
      rd(4'd7, v);
      checks++; if (v !== 32'h0000_0000) begin errors++; $display("FAIL chain_r7: got %h want 0", v); end
      checks++; if (bus.carry_flag !== 1'b0) begin errors++; $display("FAIL chain_carry: got %b want 0", bus.carry_flag); end
   endtask

   task automatic test_illegal();
      logic [31:0] v; int cyc; bit to;
      clear_rom(); rom[0] = 16'h2123; rom[1] = 16'h0000;
      do_start(8'h00);
      wait_done(1, cyc, to);
      checks++; if (to || cyc != 6) begin errors++; $display("FAIL illegal_latency: got %0d timeout=%0b want 6", cyc, to); end
      checks++; if (bus.illegal !== 1'b1) begin errors++; $display("FAIL illegal_set: got %b want 1", bus.illegal); end
      checks++; if (bus.alu_sel !== 4'd15) begin errors++; $display("FAIL illegal_sel_hold: got %0d want 15", bus.alu_sel); end
      rd(4'd1, v);
      checks++; if (v !== 32'h0000_F0F0) begin errors++; $display("FAIL illegal_r1: got %h want 0000f0f0", v); end
      rom[0] = 16'h0000;
      do_start(8'h00);
      checks++; if (bus.illegal !== 1'b0) begin errors++; $display("FAIL illegal_clear: got %b want 0", bus.illegal); end
      wait_done(1, cyc, to);
      checks++; if (to || cyc != 3) begin errors++; $display("FAIL halt_only_latency: got %0d timeout=%0b want 3", cyc, to); end
   endtask

   task automatic test_wrap_host();
      logic [31:0] v; int cyc; bit to;
      host_write(4'd1, 32'd3);
      host_write(4'd2, 32'd4);
      clear_rom(); rom[8'hFF] = 16'h1312; rom[0] = 16'h0000;
      do_start(8'hFF);
      host_write(4'd9, 32'hDEAD_BEEF);
      // A start while busy must not restart the program.
      bus.start = 1'b1; bus.start_addr = 8'h40;
      @(posedge clk); #1;
      bus.start = 1'b0;
      wait_done(3, cyc, to);
      checks++; if (to || cyc != 6) begin errors++; $display("FAIL wrap_latency: got %0d timeout=%0b want 6", cyc, to); end
      checks++; if (bus.rom_addr !== 8'h00) begin errors++; $display("FAIL wrap_pc: got %h want 00", bus.rom_addr); end
      rd(4'd3, v);
      checks++; if (v !== 32'd7) begin errors++; $display("FAIL wrap_r3: got %h want 00000007", v); end
      rd(4'd9, v);
      checks++; if (v !== 32'd0) begin errors++; $display("FAIL busy_host_write: got %h want 0", v); end
   endtask

   task automatic test_reset_exec();
      logic [31:0] v; int cyc; bit to; bit saw_done;
      clear_rom(); rom[0] = 16'h3312; rom[1] = 16'h0000;
      do_start(8'h00);
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus.alu_sel !== 4'd3 || bus.busy !== 1'b1) begin errors++; $display("FAIL exec_state: sel=%0d busy=%b want 3/1", bus.alu_sel, bus.busy); end
      rst_n = 1'b0;
      #1;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
      checks++; if (bus.alu_sel !== 4'd1) begin errors++; $display("FAIL rst_alu_sel: got %0d want 1", bus.alu_sel); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", bus.done); end
      for (int i = 0; i < 16; i++) begin
         rd(4'(i), v);
         checks++; if (v !== 32'd0) begin errors++; $display("FAIL rst_rf%0d: got %h want 0", i, v); end
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      saw_done = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) saw_done = 1'b1;
      end
      checks++; if (saw_done) begin errors++; $display("FAIL rst_no_done: got activity=1 want 0"); end
      host_write(4'd1, 32'd2);
      rom[0] = 16'h1312;
      bus.host_we = 1'b1; bus.host_addr = 4'd2; bus.host_wdata = 32'd9;
      do_start(8'h00);
      bus.host_we = 1'b0;
      wait_done(1, cyc, to);
      checks++; if (to || cyc != 6) begin errors++; $display("FAIL restart_latency: got %0d timeout=%0b want 6", cyc, to); end
      rd(4'd3, v);
      checks++; if (v !== 32'd11) begin errors++; $display("FAIL start_with_write_r3: got %h want 0000000b", v); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_carry();
      test_chain();
      test_illegal();
      test_wrap_host();
      test_reset_exec();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
